// File: rtl/ctrl_pkg.sv
// Shared definitions for the control_unit sequencer.
//   - opcode field values (instruction bits [7:6])
//   - FSM state encoding
//   - write-back mux select values
//   - sign-extension helper for the 4-bit branch offset
package ctrl_pkg;

    localparam logic [1:0] OP_ALUR = 2'b00;
    localparam logic [1:0] OP_ALUI = 2'b01;
    localparam logic [1:0] OP_MEM  = 2'b10;
    localparam logic [1:0] OP_BEQZ = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;

    function automatic logic [7:0] sext4(input logic [3:0] v);
        return {{4{v[3]}}, v};
    endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter register for control_unit.
//   clk, reset : clock, asynchronous active-low reset (loads RESET_PC)
//   adv        : advance the PC at this edge (last state of an instruction)
//   taken      : add the sign-extended offset as well (taken BEQZ)
//   off        : 4-bit signed branch offset
//   pc         : current program counter
// All arithmetic is modulo 256, so 8'hFF + 1 wraps to 8'h00.
module pc_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       adv,
    input  logic       taken,
    input  logic [3:0] off,
    output logic [7:0] pc
);
    import ctrl_pkg::*;

    logic [7:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (adv) begin
            pc_d = pc_q + 8'd1 + (taken ? sext4(off) : 8'd0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer driving the processor datapath controls.
// FSM: FETCH -> DECODE -> EXEC -> {MEM} -> {WB} -> FETCH.
//   clk, reset          : clock, asynchronous active-low reset
//   run                 : start a new instruction (sampled in FETCH only)
//   instruction         : byte at pc_addr (combinational from imem)
//   readData1           : register-file data for rs1_addr
//   pc_addr             : program counter
//   rs1/rs2/wr_addr     : register-file addresses
//   alu_op, immediate   : ALU controls, valid from EXEC through WB
//   reg_wr_en, wr, rd   : registered one-cycle strobes
//   add                 : data-memory address, latched in EXEC
//   regWriteSrc         : write-back select (WB_ALU / WB_MEM)
//   busy                : high in every state except FETCH
// Every output except busy/pc_addr is a flop whose next value is computed
// on the transition into the state where it must be valid, so strobes line
// up exactly with their state and cannot glitch.
module control_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] instruction,
    input  logic [7:0] readData1,
    output logic [7:0] pc_addr,
    output logic [1:0] rs1_addr,
    output logic [1:0] rs2_addr,
    output logic [1:0] wr_addr,
    output logic [1:0] alu_op,
    output logic [1:0] immediate,
    output logic       reg_wr_en,
    output logic       wr,
    output logic       rd,
    output logic [7:0] add,
    output logic [1:0] regWriteSrc,
    output logic       busy
);
    import ctrl_pkg::*;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [1:0] rs1_q, rs1_d, rs2_q, rs2_d, wa_q, wa_d;
    logic [1:0] alu_op_q, alu_op_d, imm_q, imm_d, wb_src_q, wb_src_d;
    logic [7:0] add_q, add_d;
    logic       reg_wr_en_q, reg_wr_en_d, wr_q, wr_d, rd_q, rd_d;
    logic       pc_adv, pc_taken;

    pc_unit #(.RESET_PC(RESET_PC)) u_pc (
        .clk   (clk),
        .reset (reset),
        .adv   (pc_adv),
        .taken (pc_taken),
        .off   (ir_q[3:0]),
        .pc    (pc_addr)
    );

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        wa_d        = wa_q;
        alu_op_d    = alu_op_q;
        imm_d       = imm_q;
        wb_src_d    = wb_src_q;
        add_d       = add_q;
        reg_wr_en_d = 1'b0;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        pc_adv      = 1'b0;
        pc_taken    = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (run) begin
                    ir_d    = instruction;
                    state_d = S_DECODE;
                    // Memory ops read the base register first so EXEC can
                    // capture the address from readData1.
                    rs1_d = (instruction[7:6] == OP_MEM) ? instruction[2:1]
                                                         : instruction[5:4];
                    rs2_d = (instruction[7:6] == OP_ALUR) ? instruction[3:2]
                                                          : 2'b00;
                end
            end
            S_DECODE: begin
                state_d  = S_EXEC;
                alu_op_d = 2'b00;
                imm_d    = 2'b00;
                case (ir_q[7:6])
                    OP_ALUR: alu_op_d = ir_q[1:0];
                    OP_ALUI: begin
                        alu_op_d = ir_q[3:2];
                        imm_d    = ir_q[1:0];
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                case (ir_q[7:6])
                    OP_MEM: begin
                        state_d = S_MEM;
                        add_d   = readData1;
                        rs1_d   = ir_q[4:3];   // data register for the store
                        if (ir_q[5]) rd_d = 1'b1;
                        else         wr_d = 1'b1;
                    end
                    OP_BEQZ: begin
                        state_d  = S_FETCH;
                        pc_adv   = 1'b1;
                        pc_taken = (readData1 == 8'd0);
                    end
                    default: begin
                        state_d     = S_WB;
                        reg_wr_en_d = 1'b1;
                        wa_d        = ir_q[5:4];
                        wb_src_d    = WB_ALU;
                    end
                endcase
            end
            S_MEM: begin
                if (ir_q[5]) begin
                    state_d     = S_WB;
                    reg_wr_en_d = 1'b1;
                    wa_d        = ir_q[4:3];
                    wb_src_d    = WB_MEM;
                end else begin
                    state_d = S_FETCH;
                    pc_adv  = 1'b1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                pc_adv  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            ir_q        <= 8'd0;
            rs1_q       <= 2'd0;
            rs2_q       <= 2'd0;
            wa_q        <= 2'd0;
            alu_op_q    <= 2'd0;
            imm_q       <= 2'd0;
            wb_src_q    <= WB_ALU;
            add_q       <= 8'd0;
            reg_wr_en_q <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            wa_q        <= wa_d;
            alu_op_q    <= alu_op_d;
            imm_q       <= imm_d;
            wb_src_q    <= wb_src_d;
            add_q       <= add_d;
            reg_wr_en_q <= reg_wr_en_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
        end
    end

    assign rs1_addr    = rs1_q;
    assign rs2_addr    = rs2_q;
    assign wr_addr     = wa_q;
    assign alu_op      = alu_op_q;
    assign immediate   = imm_q;
    assign regWriteSrc = wb_src_q;
    assign add         = add_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign wr          = wr_q;
    assign rd          = rd_q;
    assign busy        = (state_q != S_FETCH);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios followed by
// randomized programs, all checked against an instruction-level model.
module tb_control_unit;

    logic       clk, reset, run;
    logic [7:0] instruction, readData1, pc_addr, add;
    logic [1:0] rs1_addr, rs2_addr, wr_addr, alu_op, immediate, regWriteSrc;
    logic       reg_wr_en, wr, rd, busy;

    logic [7:0] imem [256];
    logic [7:0] rf   [4];

    int n_chk  = 0;
    int n_pass = 0;

    assign instruction = imem[pc_addr];
    assign readData1   = rf[rs1_addr];

    control_unit #(.RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .run(run), .instruction(instruction),
        .readData1(readData1), .pc_addr(pc_addr), .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr), .wr_addr(wr_addr), .alu_op(alu_op),
        .immediate(immediate), .reg_wr_en(reg_wr_en), .wr(wr), .rd(rd),
        .add(add), .regWriteSrc(regWriteSrc), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: executes the instruction at the current PC at the
    // instruction level. Entered at a negedge with the DUT in FETCH; returns
    // at the negedge of the following FETCH.
    // run_mode: 0 = run held high, 1 = dropped in DECODE, 2 = random after fetch
    task automatic exec_one(input int run_mode);
        logic [7:0] p, b, exp_pc, base_v;
        logic [1:0] cls;
        logic       ld, e_wen, e_rd, e_wr, e_busy;
        int         lat;
        run    = 1'b1;
        p      = pc_addr;
        b      = imem[p];
        cls    = b[7:6];
        ld     = b[5];
        base_v = rf[b[2:1]];
        lat    = (cls == 2'b10) ? (ld ? 5 : 4) : ((cls == 2'b11) ? 3 : 4);
        exp_pc = p + 8'd1;
        if (cls == 2'b11 && rf[b[5:4]] == 8'd0)
            exp_pc = p + 8'd1 + {{4{b[3]}}, b[3:0]};
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clk);
            e_wen  = (k == lat) && (cls[1] == 1'b0 || (cls == 2'b10 && ld));
            e_rd   = (k == 4) && cls == 2'b10 && ld;
            e_wr   = (k == 4) && cls == 2'b10 && !ld;
            e_busy = (k > 1);
            chk("strobes{wen,rd,wr,busy}", {reg_wr_en, rd, wr, busy},
                {e_wen, e_rd, e_wr, e_busy});
            if (k == 2) begin
                chk("rs1_decode", rs1_addr, (cls == 2'b10) ? b[2:1] : b[5:4]);
                if (cls == 2'b00) chk("rs2_decode", rs2_addr, b[3:2]);
            end
            if (k == 3 && cls[1] == 1'b0) begin
                chk("alu_op", alu_op, (cls == 2'b00) ? b[1:0] : b[3:2]);
                chk("immediate", immediate, (cls == 2'b00) ? 2'b00 : b[1:0]);
            end
            if (k == 4 && cls == 2'b10) begin
                chk("mem_add", add, base_v);
                if (!ld) chk("store_data_reg", rs1_addr, b[4:3]);
            end
            if (e_wen) begin
                chk("wr_addr", wr_addr, (cls == 2'b10) ? b[4:3] : b[5:4]);
                chk("wb_src", regWriteSrc, (cls == 2'b10) ? 2'b01 : 2'b00);
            end
            if (run_mode == 1 && k == 2) run = 1'b0;
            if (run_mode == 2 && k >= 2) run = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("pc_next", pc_addr, exp_pc);
    endtask

    task automatic idle(input int n);
        logic [7:0] p;
        run = 1'b0;
        p   = pc_addr;
        repeat (n) begin
            @(negedge clk);
            chk("idle_quiet", {reg_wr_en, rd, wr, busy}, 4'b0000);
            chk("idle_pc", pc_addr, p);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        run   = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc_addr, 8'h00);
        chk("rst_add", add, 8'h00);
        chk("rst_addrs", {rs1_addr, rs2_addr, wr_addr}, 6'd0);
        chk("rst_ctl", {alu_op, immediate, regWriteSrc}, 6'd0);
        chk("rst_strobes", {reg_wr_en, rd, wr, busy}, 4'b0000);
        reset = 1'b1;
        idle(20);

        // ALU-R, load (run dropped in DECODE), store
        imem[0] = 8'h1B;
        imem[1] = 8'hB4;
        imem[2] = 8'h8A;
        rf[2]   = 8'h40;
        rf[1]   = 8'h10;
        exec_one(0);
        chk("alur_pc", pc_addr, 8'h01);
        exec_one(1);
        idle(5);
        exec_one(0);

        // BEQZ at PC 5: taken back to 4, then not taken to 6
        imem[3] = 8'h00;
        imem[4] = 8'h00;
        imem[5] = 8'hCE;
        rf[0]   = 8'h00;
        repeat (3) exec_one(0);
        chk("beqz_taken_pc", pc_addr, 8'h04);
        rf[0] = 8'h07;
        repeat (2) exec_one(0);
        chk("beqz_nt_pc", pc_addr, 8'h06);

        // March forward through ALU ops to 8'hFF, then wrap via untaken BEQZ
        for (int i = 6; i < 255; i++) imem[i] = 8'($urandom_range(0, 127));
        imem[255] = 8'hD0;
        rf[1]     = 8'h33;
        for (int g = 0; g < 300 && pc_addr != 8'hFF; g++) exec_one(0);
        chk("reach_ff", pc_addr, 8'hFF);
        exec_one(0);
        chk("wrap_pc", pc_addr, 8'h00);

        // Halt idiom stays put
        imem[0] = 8'hCF;
        rf[0]   = 8'h00;
        repeat (2) exec_one(0);
        chk("halt_pc", pc_addr, 8'h00);

        // Reset during the MEM cycle of a store
        imem[0] = 8'h8A;
        run = 1'b1;
        repeat (3) @(negedge clk);
        chk("store_wr_before_rst", wr, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst_mid_wr", wr, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_pc", pc_addr, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        idle(3);

        // Randomized programs with random register contents
        for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
        for (int n = 0; n < 300; n++) begin
            for (int r = 0; r < 4; r++)
                rf[r] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            exec_one(2);
            if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer that drives the `processor` datapath control inputs. Owns the program counter, fetches each byte from instruction memory via `pc_addr`, and steps an FSM through fetch/decode/execute/memory/write-back. Generates the register-file, ALU, data-memory and write-back-mux controls cycle by cycle. It sits beside `processor` in the top level: it consumes `instruction` and `readData1`, and drives every control input.

## Interface
- `RESET_PC`, 8'h00, PC value loaded on reset
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `run`  in  1  start a new instruction from FETCH when high
- `instruction`  in  8  byte from instruction memory at `pc_addr`, combinational
- `readData1`  in  8  register-file read data for `rs1_addr`
- `pc_addr`  out  8  program counter
- `rs1_addr`, `rs2_addr`, `wr_addr`  out  2 each  register-file addresses
- `alu_op`  out  2  ALU operation
- `immediate`  out  2  immediate operand
- `reg_wr_en`  out  1  register-file write strobe
- `wr`, `rd`  out  1 each  data-memory write and read strobes
- `add`  out  8  data-memory address
- `regWriteSrc`  out  2  write-back select: 00 = ALU, 01 = memory
- `busy`  out  1  high in every state except FETCH

## Operation
- Instruction register `ir` latches `instruction` at the end of FETCH when `run` = 1. If `run` = 0, the block holds FETCH with all strobes low.
- Encoding, by `ir[7:6]`:
  - 00 ALU-R: rd/rs1 = [5:4], rs2 = [3:2], alu_op = [1:0]
  - 01 ALU-I: rd/rs1 = [5:4], alu_op = [3:2], imm = [1:0]
  - 10 MEM: [5] = 1 for load, 0 for store; data reg = [4:3]; base reg = [2:1]; address = `readData1` of the base register
  - 11 BEQZ: rs = [5:4], off = [3:0] signed
- States: FETCH → DECODE → EXEC, then:
  - ALU-R / ALU-I: WB → FETCH
  - Load: MEM → WB → FETCH
  - Store: MEM → FETCH
  - BEQZ: → FETCH
- DECODE:
  - Drive `rs1_addr`/`rs2_addr` from `ir`.
  - For a store, `rs1_addr` carries the base register. In MEM, `rs1_addr` switches to the data register.
- EXEC:
  - `alu_op`/`immediate` valid (held through WB).
  - For MEM, latch `add` <= `readData1`.
- MEM:
  - Load: `rd` = 1 for exactly one cycle.
  - Store: `wr` = 1 for exactly one cycle, with the data register on `rs1_addr`.
- WB: `reg_wr_en` = 1 for exactly one cycle; `regWriteSrc` = 00 for ALU, 01 for load; `wr_addr` = rd.
- PC update on the last state of each instruction:
  - Default: `pc_addr` + 1.
  - BEQZ taken (`readData1` == 0 in EXEC): `pc_addr` + 1 + sext(off).
  - Arithmetic is mod 256; wrap 8'hFF→8'h00 is legal.
- BEQZ with off = 4'hF and rs == 0 re-executes itself forever; this is the halt idiom.

## Timing
- Reset (async assert, sync release):
  - State = FETCH, `pc_addr` = `RESET_PC`, `add` = 0.
  - All addresses, `alu_op`, `immediate` and `regWriteSrc` = 0.
  - All strobes, and `busy`, = 0.
- Latency from FETCH: ALU 4 cycles, load 5, store 4, BEQZ 3.
- Strobes (`reg_wr_en`, `wr`, `rd`) are registered outputs, glitch-free, and never high simultaneously.
- Load data is valid in the cycle after `rd`, which is the WB cycle.
- `run` is sampled only in FETCH. Deasserting `run` mid-instruction does not abort; the instruction completes.
- Reset mid-instruction: immediate return to FETCH with no partial write. A strobe high at assertion drops asynchronously.

## Structure
- Shared package `ctrl_pkg` contains:
  - opcode constants (OP_ALUR, OP_ALUI, OP_MEM, OP_BEQZ)
  - state enum (S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB)
  - write-back select constants (WB_ALU = 2'b00, WB_MEM = 2'b01)
- One sub-module, `pc_unit`: the PC register with increment/branch adder and `RESET_PC` load.
- The FSM and output registers stay in `control_unit`.

## Test plan
- Reset, then `run` = 1 with `instruction` = 8'h1B (ALU-R rd 1, rs2 2, op 3) → `reg_wr_en` high in cycle 4 only, `wr_addr` = 1, `alu_op` = 3, `pc_addr` = 1 afterwards.
- Load 8'hB4 (rd 2, base 2) with `readData1` = 8'h40 → `add` = 8'h40, `rd` pulse in cycle 4, `reg_wr_en` with `regWriteSrc` = 01 in cycle 5.
- Store 8'h8A with `readData1` = 8'h10 in EXEC → single `wr` pulse in cycle 4, `add` = 8'h10, no `reg_wr_en`.
- BEQZ 8'hCE at PC 8'h05: with `readData1` = 0 → `pc_addr` = 8'h04; with `readData1` = 8'h07 → `pc_addr` = 8'h06. At PC 8'hFF with off = 0, not taken → `pc_addr` = 8'h00.
- `run` = 0 after reset → `pc_addr` stays 0, `busy` = 0, no strobes for 20 cycles. Drop `run` in DECODE → the instruction completes, then the block idles.
- Assert `reset` during the MEM cycle of a store → `wr` falls immediately, state is FETCH, `pc_addr` = `RESET_PC`.
